// File: rtl/decode_stage.sv
// Registered IF/ID decode stage for the RV32I pipeline.
// Define DECODE_PERF_CNT_EN to add the perf_decoded/perf_illegal counters.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            rd_we,
    output logic            illegal
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]     perf_decoded,
    output logic [31:0]     perf_illegal
`endif
);

    logic [6:0]  op;
    logic        is_r, is_i, is_s, is_b, is_u, is_j;
    logic [4:0]  d_rd, d_rs1, d_rs2;
    logic [2:0]  d_f3, d_fmt;
    logic [6:0]  d_f7;
    logic [31:0] d_imm;
    logic        d_ill, d_we;
    logic        capture;

    assign op   = in_instr[6:0];
    assign is_r = (op == 7'b0110011);
    assign is_i = (op == 7'b0010011) || (op == 7'b0000011) ||
                  (op == 7'b1100111) || (op == 7'b1110011);
    assign is_s = (op == 7'b0100011);
    assign is_b = (op == 7'b1100011);
    assign is_u = (op == 7'b0110111) || (op == 7'b0010111);
    assign is_j = (op == 7'b1101111);

    always_comb begin
        d_rd  = '0;
        d_rs1 = '0;
        d_rs2 = '0;
        d_f3  = '0;
        d_f7  = '0;
        d_imm = '0;
        d_fmt = 3'd7;
        d_ill = 1'b0;
        unique case (1'b1)
            is_r: begin
                d_fmt = 3'd0;
                d_rd  = in_instr[11:7];
                d_f3  = in_instr[14:12];
                d_rs1 = in_instr[19:15];
                d_rs2 = in_instr[24:20];
                d_f7  = in_instr[31:25];
            end
            is_i: begin
                d_fmt = 3'd1;
                d_rd  = in_instr[11:7];
                d_f3  = in_instr[14:12];
                d_rs1 = in_instr[19:15];
                d_imm = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            is_s: begin
                d_fmt = 3'd2;
                d_f3  = in_instr[14:12];
                d_rs1 = in_instr[19:15];
                d_rs2 = in_instr[24:20];
                d_imm = {{20{in_instr[31]}}, in_instr[31:25],
                         in_instr[11:7]};
            end
            is_b: begin
                d_fmt = 3'd3;
                d_f3  = in_instr[14:12];
                d_rs1 = in_instr[19:15];
                d_rs2 = in_instr[24:20];
                d_imm = {{20{in_instr[31]}}, in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
            end
            is_u: begin
                d_fmt = 3'd4;
                d_rd  = in_instr[11:7];
                d_imm = {in_instr[31:12], 12'b0};
            end
            is_j: begin
                d_fmt = 3'd5;
                d_rd  = in_instr[11:7];
                d_imm = {{12{in_instr[31]}}, in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            end
            default: d_ill = 1'b1;
        endcase
    end

    assign d_we     = (is_r | is_i | is_u | is_j) && (d_rd != 5'd0);
    assign in_ready = !out_valid || out_ready;
    // flush wins over a same-cycle capture: the incoming word is dropped
    assign capture  = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            opcode    <= '0;
            rd        <= '0;
            funct3    <= '0;
            rs1       <= '0;
            rs2       <= '0;
            funct7    <= '0;
            imm       <= '0;
            fmt       <= '0;
            rd_we     <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (capture)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
            if (capture) begin
                out_pc  <= in_pc;
                opcode  <= op;
                rd      <= d_rd;
                funct3  <= d_f3;
                rs1     <= d_rs1;
                rs2     <= d_rs2;
                funct7  <= d_f7;
                imm     <= XLEN'($signed(d_imm));
                fmt     <= d_fmt;
                rd_we   <= d_we;
                illegal <= d_ill;
            end
        end
    end

`ifdef DECODE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_decoded <= '0;
            perf_illegal <= '0;
        end else if (out_valid && out_ready) begin
            perf_decoded <= perf_decoded + 32'd1;
            if (illegal)
                perf_illegal <= perf_illegal + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected beats queued at handshake,
// popped and compared when the stage presents an accepted output beat.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        we;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3, fmt;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        rd_we, illegal;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_decoded, perf_illegal;
`endif

    int   n_run = 0;
    int   n_fail = 0;
    int   m_dec = 0;
    int   m_ill = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .opcode(opcode), .rd(rd),
        .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .imm(imm), .fmt(fmt),
        .rd_we(rd_we), .illegal(illegal)
`ifdef DECODE_PERF_CNT_EN
        , .perf_decoded(perf_decoded), .perf_illegal(perf_illegal)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(logic [31:0] pc, logic [6:0] op,
        logic [4:0] rd_, logic [2:0] f3, logic [4:0] s1, logic [4:0] s2,
        logic [6:0] f7, logic [31:0] im, logic [2:0] fm, logic we,
        logic ill);
        exp_t e;
        e = '{pc, op, rd_, f3, s1, s2, f7, im, fm, we, ill};
        return e;
    endfunction

    function automatic exp_t ref_decode(logic [31:0] i, logic [31:0] pc);
        exp_t e;
        e = '0;
        e.pc = pc;
        e.op = i[6:0];
        case (i[6:0])
            7'h33: begin
                e.fmt = 3'd0; e.rd = i[11:7]; e.f3 = i[14:12];
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.f7 = i[31:25];
            end
            7'h13, 7'h03, 7'h67, 7'h73: begin
                e.fmt = 3'd1; e.rd = i[11:7]; e.f3 = i[14:12];
                e.rs1 = i[19:15];
                e.imm = 32'($signed(i) >>> 20);
            end
            7'h23: begin
                e.fmt = 3'd2; e.f3 = i[14:12];
                e.rs1 = i[19:15]; e.rs2 = i[24:20];
                e.imm = 32'($signed({i[31:25], i[11:7]}));
            end
            7'h63: begin
                e.fmt = 3'd3; e.f3 = i[14:12];
                e.rs1 = i[19:15]; e.rs2 = i[24:20];
                e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4; e.rd = i[11:7];
                e.imm = i & 32'hFFFF_F000;
            end
            7'h6F: begin
                e.fmt = 3'd5; e.rd = i[11:7];
                e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            end
            default: begin
                e.fmt = 3'd7; e.ill = 1'b1;
            end
        endcase
        e.we = !e.ill && e.fmt != 3'd2 && e.fmt != 3'd3 && e.rd != 5'd0;
        return e;
    endfunction

    task automatic mon();
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", {32'd0, out_pc}, 64'hDEAD);
            end else begin
                e = sb.pop_front();
                m_dec++;
                if (e.ill) m_ill++;
                chk("pc", out_pc, e.pc);
                chk("opcode", opcode, e.op);
                chk("rd", rd, e.rd);
                chk("funct3", funct3, e.f3);
                chk("rs1", rs1, e.rs1);
                chk("rs2", rs2, e.rs2);
                chk("funct7", funct7, e.f7);
                chk("imm", imm, e.imm);
                chk("fmt", fmt, e.fmt);
                chk("rd_we", rd_we, e.we);
                chk("illegal", illegal, e.ill);
            end
        end
    endtask

    task automatic nedge();
        @(negedge clk);
        mon();
    endtask

    // called at posedge+1; returns at posedge+1 after the capture edge
    task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                        input exp_t e);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        nedge();
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            t++;
            nedge();
        end
        if (in_ready) sb.push_back(e);
        else chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && t < 50) begin
            t++;
            nedge();
        end
        nedge();
        chk("drain_left", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    logic [31:0] s_pc, s_imm;
    logic [4:0]  s_rd;
    logic [31:0] r;
    logic [6:0]  ops [12];

    initial begin
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23,
                7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h32};

        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pc", out_pc, 0);
        chk("rst_imm", imm, 0);
        chk("rst_fmt", fmt, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_rd_we", rd_we, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(32'h002081B3, 32'h100,
             mk(32'h100, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0,
                32'd0, 3'd0, 1'b1, 1'b0));
        send(32'hFFF00293, 32'h104,
             mk(32'h104, 7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0,
                32'hFFFF_FFFF, 3'd1, 1'b1, 1'b0));
        send(32'h0020A423, 32'h108,
             mk(32'h108, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0,
                32'd8, 3'd2, 1'b0, 1'b0));
        send(32'hFE000EE3, 32'h10C,
             mk(32'h10C, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0,
                32'hFFFF_FFFC, 3'd3, 1'b0, 1'b0));
        send(32'h00000000, 32'h110,
             mk(32'h110, 7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0,
                32'd0, 3'd7, 1'b0, 1'b1));
        drain();
        chk("beats_after_t6", m_dec, 5);
`ifdef DECODE_PERF_CNT_EN
        chk("perf_decoded_t6", perf_decoded, 5);
        chk("perf_illegal_t6", perf_illegal, 1);
`endif

        // stall: three streamed, then downstream holds for two cycles
        for (int k = 0; k < 3; k++)
            send(32'h00100093 + (k << 20), 32'h200 + 4 * k,
                 ref_decode(32'h00100093 + (k << 20), 32'h200 + 4 * k));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h123452B7;
        in_pc     = 32'h20C;
        nedge();
        chk("stall_in_ready0", in_ready, 0);
        s_pc  = out_pc;
        s_imm = imm;
        s_rd  = rd;
        nedge();
        chk("stall_in_ready1", in_ready, 0);
        chk("stall_valid", out_valid, 1);
        chk("stall_pc", out_pc, s_pc);
        chk("stall_imm", imm, s_imm);
        chk("stall_rd", rd, s_rd);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h123452B7, 32'h20C, ref_decode(32'h123452B7, 32'h20C));
        drain();

        // flush kills held beat and the incoming one
        out_ready = 1'b0;
        send(32'h00500513, 32'h300, ref_decode(32'h00500513, 32'h300));
        in_valid = 1'b1;
        in_instr = 32'h00600593;
        in_pc    = 32'h304;
        flush    = 1'b1;
        nedge();
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        nedge();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_held_q", sb.size(), 1);
        sb.delete();
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) nedge();
        chk("flush_no_ghost", out_valid, 0);
        @(posedge clk); #1;

        for (int k = 0; k < 24; k++) begin
            r = $urandom();
            r[6:0] = ops[$urandom_range(0, 11)];
            out_ready = 1'($urandom_range(0, 1));
            send(r, 32'h400 + 4 * k, ref_decode(r, 32'h400 + 4 * k));
        end
        drain();
`ifdef DECODE_PERF_CNT_EN
        chk("perf_decoded_end", perf_decoded, m_dec);
        chk("perf_illegal_end", perf_illegal, m_ill);
`endif

        // asynchronous reset between edges
        out_ready = 1'b0;
        send(32'hFFF00293, 32'h500, ref_decode(32'hFFF00293, 32'h500));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_imm", imm, 0);
        chk("arst_pc", out_pc, 0);
        sb.delete();
        #2;
        rst_n = 1'b1;
`ifdef DECODE_PERF_CNT_EN
        chk("arst_perf", perf_decoded, 0);
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
